// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared alphabet constants, sequencer states and key reduction
//
// Contents:
//   ALPHA      alphabet size; letter codes at or above it are invalid
//   LETTER_W   width of one letter code
//   state_t    sequencer FSM states (VISSUE/VWAIT only reached with CIPHER_VERIFY_EN)
//   reduce_key folds a 5-bit key into 0..ALPHA-1
package cipher_pkg;

  localparam int ALPHA    = 26;
  localparam int LETTER_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_VISSUE,
    S_VWAIT,
    S_DONE
  } state_t;

  // A 5-bit key spans 0..31, so one conditional subtraction is enough.
  function automatic logic [LETTER_W-1:0] reduce_key(input logic [LETTER_W-1:0] key);
    logic [LETTER_W-1:0] alpha_w;
    alpha_w = LETTER_W'(ALPHA);
    return (key >= alpha_w) ? key - alpha_w : key;
  endfunction

endpackage

// File: rtl/cipher_msg_buf.sv
// rtl/cipher_msg_buf.sv - DEPTH x LETTER_W register file, one write port, two async read ports
//
// Ports:
//   clk               write clock
//   we, waddr, wdata  synchronous write port
//   ra_addr, ra_data  combinational read port A
//   rb_addr, rb_data  combinational read port B
// Storage is not reset; contents are don't-care until written.
module cipher_msg_buf
  import cipher_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [LETTER_W-1:0] wdata,
  input  logic [AW-1:0]       ra_addr,
  output logic [LETTER_W-1:0] ra_data,
  input  logic [AW-1:0]       rb_addr,
  output logic [LETTER_W-1:0] rb_data
);

  logic [LETTER_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/cipher_msg_sequencer.sv
// rtl/cipher_msg_sequencer.sv - buffers a message and feeds it one letter at a time through the cipher engine
//
// Optional build macro: CIPHER_VERIFY_EN (round-trip each result back through the engine).
//
// Ports:
//   clk, resetn                      clock (CLOCK_50 domain), asynchronous active-low reset
//   load, char_in                    append one letter code to the message
//   clear                            empty the message and clear sticky flags (IDLE/DONE only)
//   go, decode, cipher_key           start a run; direction and key sampled at go
//   eng_start, eng_data, eng_key,
//   eng_decode                       request side of the engine handshake
//   eng_done, eng_result             completion side of the engine handshake
//   busy, done                       run in progress / one-cycle completion pulse
//   msg_len                          number of letters loaded
//   rd_addr, rd_data                 combinational read of the result buffer
//   overflow, invalid, mismatch      sticky status flags
module cipher_msg_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int ALPHA = 26
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic [4:0]    char_in,
  input  logic          clear,
  input  logic          go,
  input  logic          decode,
  input  logic [4:0]    cipher_key,
  output logic          eng_start,
  output logic [4:0]    eng_data,
  output logic [4:0]    eng_key,
  output logic          eng_decode,
  input  logic          eng_done,
  input  logic [4:0]    eng_result,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   msg_len,
  input  logic [AW-1:0] rd_addr,
  output logic [4:0]    rd_data,
  output logic          overflow,
  output logic          invalid,
  output logic          mismatch
);

  import cipher_pkg::*;

  localparam logic [AW:0]         LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [LETTER_W-1:0] ALPHA_W  = LETTER_W'(ALPHA);

  state_t              state, state_nx;
  logic [AW-1:0]       idx;
  logic [AW:0]         len_r;
  logic [LETTER_W-1:0] key_r;
  logic [LETTER_W-1:0] data_r;
  logic                dec_r;
  logic                done_r;
  logic                ovf_r;
  logic                inv_r;

  logic [LETTER_W-1:0] msg_char;
  logic [LETTER_W-1:0] msg_spare;
  logic [LETTER_W-1:0] res_spare;
  logic                msg_we;
  logic                res_we;
  logic [LETTER_W-1:0] res_wdata;

  logic                idle_or_done;
  logic                msg_full;
  logic                is_last;
  logic                run_go;
  logic                advance;
  logic                set_inv;
  logic                done_nx;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign msg_full     = (len_r == LEN_FULL);
  assign is_last      = ({1'b0, idx} == (len_r - 1'b1));
  // clear outranks go, and go outranks load, when they coincide.
  assign msg_we       = idle_or_done && load && !clear && !go && !msg_full;

  cipher_msg_buf #(.DEPTH(DEPTH), .AW(AW)) u_msg_buf (
    .clk     (clk),
    .we      (msg_we),
    .waddr   (len_r[AW-1:0]),
    .wdata   (char_in),
    .ra_addr (idx),
    .ra_data (msg_char),
    .rb_addr (rd_addr),
    .rb_data (msg_spare)
  );

  cipher_msg_buf #(.DEPTH(DEPTH), .AW(AW)) u_res_buf (
    .clk     (clk),
    .we      (res_we),
    .waddr   (idx),
    .wdata   (res_wdata),
    .ra_addr (rd_addr),
    .ra_data (rd_data),
    .rb_addr (idx),
    .rb_data (res_spare)
  );

  // Second read ports are not needed by the sequencer itself.
  logic unused_spare;
  assign unused_spare = ^{msg_spare, res_spare};

`ifdef CIPHER_VERIFY_EN
  logic set_mis;
  logic mis_r;
`endif

  always_comb begin
    state_nx  = state;
    res_we    = 1'b0;
    res_wdata = eng_result;
    run_go    = 1'b0;
    advance   = 1'b0;
    set_inv   = 1'b0;
    done_nx   = 1'b0;
`ifdef CIPHER_VERIFY_EN
    set_mis   = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (clear) begin
          state_nx = S_IDLE;
        end else if (go) begin
          run_go = 1'b1;
          if (len_r == '0) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        // Out-of-alphabet codes bypass the engine and are copied through.
        if (msg_char >= ALPHA_W) begin
          res_we    = 1'b1;
          res_wdata = msg_char;
          set_inv   = 1'b1;
          advance   = 1'b1;
        end else begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          res_we = 1'b1;
`ifdef CIPHER_VERIFY_EN
          state_nx = S_VISSUE;
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef CIPHER_VERIFY_EN
      S_VISSUE: begin
        state_nx = S_VWAIT;
      end
      S_VWAIT: begin
        if (eng_done) begin
          set_mis = (eng_result != msg_char);
          advance = 1'b1;
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (advance) begin
      if (is_last) begin
        state_nx = S_DONE;
        done_nx  = 1'b1;
      end else begin
        state_nx = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      idx    <= '0;
      len_r  <= '0;
      key_r  <= '0;
      data_r <= '0;
      dec_r  <= 1'b0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      inv_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= done_nx;

      if (idle_or_done) begin
        if (clear) begin
          len_r <= '0;
          ovf_r <= 1'b0;
          inv_r <= 1'b0;
        end else if (go) begin
          key_r <= reduce_key(cipher_key);
          dec_r <= decode;
        end else if (load) begin
          if (msg_full) begin
            ovf_r <= 1'b1;
          end else begin
            len_r <= len_r + 1'b1;
          end
        end
      end

      if (run_go) begin
        idx <= '0;
      end else if (advance && !is_last) begin
        idx <= idx + 1'b1;
      end

      if (set_inv) begin
        inv_r <= 1'b1;
      end

      // eng_data is captured once per letter so it stays put for the whole request.
      if (state == S_FETCH) begin
        data_r <= msg_char;
      end
`ifdef CIPHER_VERIFY_EN
      if (state == S_WAIT && eng_done) begin
        data_r <= eng_result;
      end
`endif
    end
  end

`ifdef CIPHER_VERIFY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mis_r <= 1'b0;
    end else if (idle_or_done && clear) begin
      mis_r <= 1'b0;
    end else if (set_mis) begin
      mis_r <= 1'b1;
    end
  end

  assign mismatch   = mis_r;
  assign eng_start  = (state == S_ISSUE) || (state == S_VISSUE);
  // The check pass runs the opposite direction with the same key.
  assign eng_decode = dec_r ^ ((state == S_VISSUE) || (state == S_VWAIT));
`else
  assign mismatch   = 1'b0;
  assign eng_start  = (state == S_ISSUE);
  assign eng_decode = dec_r;
`endif

  assign eng_data = data_r;
  assign eng_key  = key_r;
  assign busy     = !idle_or_done;
  assign done     = done_r;
  assign msg_len  = len_r;
  assign overflow = ovf_r;
  assign invalid  = inv_r;

endmodule

// File: tb/tb_cipher_msg_sequencer.sv
// tb/tb_cipher_msg_sequencer.sv - scoreboard bench for cipher_msg_sequencer with a behavioural engine
module tb_cipher_msg_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          resetn;
  logic          load;
  logic [4:0]    char_in;
  logic          clear;
  logic          go;
  logic          decode;
  logic [4:0]    cipher_key;
  logic          eng_start;
  logic [4:0]    eng_data;
  logic [4:0]    eng_key;
  logic          eng_decode;
  logic          eng_done;
  logic [4:0]    eng_result;
  logic          busy;
  logic          done;
  logic [AW:0]   msg_len;
  logic [AW-1:0] rd_addr;
  logic [4:0]    rd_data;
  logic          overflow;
  logic          invalid;
  logic          mismatch;

  cipher_msg_sequencer #(.DEPTH(DEPTH), .AW(AW), .ALPHA(26)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .char_in    (char_in),
    .clear      (clear),
    .go         (go),
    .decode     (decode),
    .cipher_key (cipher_key),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_key    (eng_key),
    .eng_decode (eng_decode),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy),
    .done       (done),
    .msg_len    (msg_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .overflow   (overflow),
    .invalid    (invalid),
    .mismatch   (mismatch)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int eng_lat  = 1;
  int done_cnt = 0;
  int busy_cnt = 0;
  int start_cnt = 0;
  int last_key = -1;
  int msg_q[$];
  int exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int caesar(input int c, input int k, input bit dec);
    int kr;
    kr = k % 26;
    if (c >= 26) return c;
    if (dec) return (c - kr + 26) % 26;
    return (c + kr) % 26;
  endfunction

  // Engine model: answers each request eng_lat cycles after it is issued.
  initial begin
    int  d, k, lat;
    bit  dec, abort;
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (resetn && eng_start) begin
        d = eng_data; k = eng_key; dec = eng_decode; lat = eng_lat; abort = 0;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (!resetn) abort = 1;
          if (!abort) begin
            check("eng_data_hold", eng_data, d);
            check("eng_key_hold", eng_key, k);
          end
        end
        @(negedge clk);
        if (!resetn) abort = 1;
        if (!abort) begin
          check("eng_data_hold", eng_data, d);
          eng_result = 5'(caesar(d, k, dec));
          eng_done   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (eng_start) begin
        start_cnt++;
        last_key = eng_key;
      end
    end
  end

  task automatic load_char(input int c);
    @(negedge clk);
    load = 1'b1; char_in = 5'(c);
    if (msg_q.size() < DEPTH) msg_q.push_back(c);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    msg_q.delete();
  endtask

  task automatic run_msg(input int key, input bit dec, input int lat,
                         input int exp_busy, input int exp_starts);
    int t;
    eng_lat = lat;
    foreach (msg_q[i]) exp_q.push_back(caesar(msg_q[i], key, dec));
    @(negedge clk);
    done_cnt = 0; busy_cnt = 0; start_cnt = 0;
    go = 1'b1; decode = dec; cipher_key = 5'(key);
    @(negedge clk);
    go = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("done_in_time", int'(t < 300), 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cnt, exp_busy);
    check("eng_starts", start_cnt, exp_starts);
    check("busy_after", busy, 0);
    if (exp_starts > 0) check("eng_key", last_key, key % 26);
    for (int i = 0; i < msg_q.size(); i++) begin
      rd_addr = AW'(i);
      #1;
      check("result", rd_data, exp_q.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    resetn = 1'b0; load = 1'b0; char_in = '0; clear = 1'b0; go = 1'b0;
    decode = 1'b0; cipher_key = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_msg_len", msg_len, 0);
    check("rst_overflow", overflow, 0);
    check("rst_invalid", invalid, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_key", eng_key, 0);
    check("rst_eng_data", eng_data, 0);
    resetn = 1'b1;

    // 'd','y','z' encoded with key 3, single-cycle engine, then re-run from DONE.
    load_char(3); load_char(24); load_char(25);
    check("len3", msg_len, 3);
    run_msg(3, 1'b0, 1, 9, 3);
    check("invalid_clean", invalid, 0);
    run_msg(3, 1'b0, 1, 9, 3);

    // Key 29 decode of 'a', four-cycle engine.
    do_clear();
    load_char(0);
    run_msg(29, 1'b1, 4, 6, 1);
    check("eng_decode", eng_decode, 1);

    // Nine loads into an eight-deep buffer, run the full buffer, then clear.
    do_clear();
    for (int i = 0; i < 9; i++) load_char((i * 3) % 26);
    check("len_full", msg_len, 8);
    check("overflow_set", overflow, 1);
    run_msg(7, 1'b0, 2, 32, 8);
    do_clear();
    check("len_cleared", msg_len, 0);
    check("overflow_cleared", overflow, 0);

    // Invalid code passes through untouched.
    load_char(2); load_char(27); load_char(5);
    run_msg(1, 1'b0, 1, 7, 2);
    check("invalid_set", invalid, 1);
    do_clear();
    check("invalid_cleared", invalid, 0);

    // Empty message: done one cycle after go, no engine traffic.
    @(negedge clk);
    done_cnt = 0; start_cnt = 0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    @(negedge clk);
    check("empty_done_pulse", done, 0);
    check("empty_starts", start_cnt, 0);

    // Reset during WAIT of the second letter.
    do_clear();
    load_char(1); load_char(2); load_char(3);
    eng_lat = 4;
    @(negedge clk);
    done_cnt = 0; start_cnt = 0;
    go = 1'b1; decode = 1'b0; cipher_key = 5'd1;
    @(negedge clk);
    go = 1'b0;
    t = 0;
    while (start_cnt < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("second_start_seen", int'(t < 100), 1);
    repeat (2) @(negedge clk);
    check("mid_wait_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_len", msg_len, 0);
    @(negedge clk);
    resetn = 1'b1;
    msg_q.delete();
    repeat (10) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);

    load_char(4);
    check("len_after_rst", msg_len, 1);
    run_msg(1, 1'b0, 1, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
